// File: rtl/ready_pkg.sv
// ready_pkg: shared FSM encoding and default wait-state counts for ready_controller
package ready_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, POLL, DONE} state_t;
  localparam int DEFAULT_IO_WAIT_STATES = 4;
  localparam int DEFAULT_MEM_WAIT_STATES = 0;
endpackage

// File: rtl/ready_sync.sv
// ready_sync: two-flop synchroniser for the per-source ready lines, advanced on CPU clock rising edges
module ready_sync #(
  parameter int WIDTH = 3
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      meta <= '0;
      q <= '0;
    end else if (enable) begin
      meta <= d;
      q <= meta;
    end
endmodule

// File: rtl/ready_controller.sv
// ready_controller: 8088 READY generator merging per-source ready with programmable waits and a bus-hang watchdog
module ready_controller
  import ready_pkg::*;
#(
  parameter int NUM_SRC        = 3,
  parameter int WS_WIDTH       = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TO_WIDTH       = 8
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                cpu_clock_posedge,
  input  logic                cpu_clock_negedge,
  input  logic                INTA_N,
  input  logic                IO_OR_M,
  input  logic                IOR_N,
  input  logic                IOW_N,
  input  logic                MEMR_N,
  input  logic                MEMW_N,
  input  logic [NUM_SRC-1:0]  ready_in,
  input  logic [NUM_SRC-1:0]  ready_mask,
  input  logic [WS_WIDTH-1:0] io_wait_states,
  input  logic [WS_WIDTH-1:0] mem_wait_states,
  input  logic                timeout_clear,
  output logic                RDY,
  output logic                timeout_pulse,
  output logic                timeout_status,
  output logic [NUM_SRC-1:0]  timeout_source
);
  localparam logic [TO_WIDTH-1:0] to_last = TO_WIDTH'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  state_t state, state_nx;
  logic [WS_WIDTH-1:0] ws, ws_load;
  logic [TO_WIDTH-1:0] to_cnt;
  logic [NUM_SRC-1:0] ready_q, stalled;
  logic cmd, src_ok, fire, hit, rdy_next;
  assign cmd = ~IOR_N | ~IOW_N | ~MEMR_N | ~MEMW_N;
  assign ws_load = IO_OR_M ? io_wait_states : mem_wait_states;
  assign src_ok = &(ready_q | ~ready_mask);
  assign stalled = ready_mask & ~ready_q;
  ready_sync #(.WIDTH(NUM_SRC)) u_sync (
    .clock(clock),
    .reset_n(reset_n),
    .enable(cpu_clock_posedge),
    .d(ready_in),
    .q(ready_q)
  );
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else if (cpu_clock_posedge) state <= state_nx;
  // A released command aborts any stalled cycle; a ready source beats the watchdog on the same edge.
  always_comb begin
    state_nx = state == IDLE ? (cmd && INTA_N ? (ws_load != '0 ? WAIT : POLL) : IDLE)
             : !cmd ? IDLE
             : state == WAIT ? (ws == WS_WIDTH'(1) ? POLL : WAIT)
             : state == POLL ? (src_ok || fire ? DONE : POLL)
             : DONE;
  end
  always_comb begin
    rdy_next = state == IDLE || state == DONE;
    fire = TIMEOUT_CYCLES != 0 && state == POLL && cmd && !src_ok && to_cnt == to_last;
    hit = cpu_clock_posedge && fire;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      ws <= '0;
      to_cnt <= '0;
    end else if (cpu_clock_posedge) begin
      ws <= state_nx == WAIT ? (state == IDLE ? ws_load : ws - WS_WIDTH'(1)) : '0;
      to_cnt <= state == POLL && state_nx == POLL ? to_cnt + TO_WIDTH'(1) : '0;
    end
  // A clear arriving with a fresh timeout drops only the old capture.
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      RDY <= 1'b0;
      timeout_pulse <= 1'b0;
      timeout_status <= 1'b0;
      timeout_source <= '0;
    end else begin
      if (cpu_clock_negedge) RDY <= rdy_next;
      timeout_pulse <= hit;
      timeout_status <= hit || (timeout_status && !timeout_clear);
      timeout_source <= (hit ? stalled : '0) | (timeout_clear ? '0 : timeout_source);
    end
endmodule

// File: doc/ready_controller.md
Name: ready_controller

Overview:
- Parametrised successor to the system READY generator for the 8088 bus.
- Merges NUM_SRC per-device ready lines with runtime-programmable fixed wait states, separately for I/O and memory cycles.
- Adds a bus-hang watchdog that force-completes a stuck cycle and records which sources stalled.
- Sits between the bus-command decode and the CPU RDY input; an INTA cycle always runs with zero waits.

Parameters:
NUM_SRC, 3, number of ready sources (video, sound, ext by default)
WS_WIDTH, 4, width of the programmable wait-state counts
TIMEOUT_CYCLES, 64, CPU clocks in the poll phase before forced completion; 0 disables the watchdog
TO_WIDTH, 8, width of the timeout counter; must satisfy TIMEOUT_CYCLES < 2**TO_WIDTH

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
cpu_clock_posedge  in  1  one-clock strobe at CPU clock rising edge
cpu_clock_negedge  in  1  one-clock strobe at CPU clock falling edge
INTA_N  in  1  interrupt acknowledge, active low
IO_OR_M  in  1  1 = I/O cycle, 0 = memory cycle
IOR_N  in  1  I/O read command
IOW_N  in  1  I/O write command
MEMR_N  in  1  memory read command
MEMW_N  in  1  memory write command
ready_in  in  NUM_SRC  per-source ready, active high
ready_mask  in  NUM_SRC  1 = source participates
io_wait_states  in  WS_WIDTH  fixed waits for I/O cycles
mem_wait_states  in  WS_WIDTH  fixed waits for memory cycles
timeout_clear  in  1  clears timeout_status and timeout_source
RDY  out  1  ready to CPU
timeout_pulse  out  1  one-clock pulse on forced completion
timeout_status  out  1  sticky timeout flag
timeout_source  out  NUM_SRC  unmasked sources not ready at timeout

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE, RDY=0, timeout_pulse=0, timeout_status=0, timeout_source=0, all counters 0.
- Command detection:
  - cmd = ~IOR_N | ~IOW_N | ~MEMR_N | ~MEMW_N.
  - io = IO_OR_M, sampled at cycle start.
- Source synchroniser: two-stage, clocked on cpu_clock_posedge.
  - src_ok = &(ready_sync | ~ready_mask).
  - All-masked → src_ok=1.
- RDY register:
  - Updates only on cpu_clock_negedge.
  - Value = rdy_next, where rdy_next=1 in IDLE/DONE/INTA, 0 in WAIT/POLL.
  - Consequently RDY=0 after reset until the first cpu_clock_negedge.
- State transitions: all evaluated on cpu_clock_posedge unless noted.
  - IDLE:
    - cmd & INTA_N=1 → load ws from io_wait_states or mem_wait_states per IO_OR_M.
    - ws>0 → WAIT; ws=0 → POLL.
    - INTA_N=0 → stay IDLE; RDY held 1.
  - WAIT: ws decrements each posedge; at ws reaching 0 → POLL.
  - POLL:
    - src_ok → DONE.
    - Otherwise to_cnt increments.
    - When TIMEOUT_CYCLES≠0 and to_cnt==TIMEOUT_CYCLES-1 → DONE with timeout:
      - timeout_pulse=1 for one clock.
      - timeout_status=1.
      - timeout_source |= mask & ~ready_sync.
  - DONE: RDY=1; when cmd=0 → IDLE, to_cnt cleared.
- Abort: cmd deasserts in WAIT or POLL → IDLE at the next posedge, no timeout, counters cleared.
- Wait-state values are captured at cycle start; changes mid-cycle have no effect.
- Simultaneous src_ok and timeout terminal count: src_ok wins, no timeout recorded.
- timeout_clear and a new timeout in the same clock: the new timeout wins (status=1, source = new bits only).
- Back-to-back cycles: DONE→IDLE→new cycle requires cmd=0 on at least one posedge.
- Reset mid-cycle: immediate return to reset values.

Decomposition:
- Package ready_pkg:
  - typedef enum state_t {IDLE, WAIT, POLL, DONE}.
  - Default wait-state localparams.
- Sub-module ready_sync, NUM_SRC-wide:
  - Two-flop synchroniser enabled by cpu_clock_posedge.
  - Outputs ready_sync.
- Top holds the FSM, counters, and timeout capture.

Test Plan:
- I/O read, io_wait_states=2, all ready=1 → RDY low for 2 CPU clocks + 1 poll clock, then high; timeout_pulse never asserts.
- Memory write, mem_wait_states=0, ready_in[1]=0 for 5 posedges then 1 → RDY returns high on the negedge after the synchroniser delay (≈7 CPU clocks).
- TIMEOUT_CYCLES=8, ready_in=3'b101 stuck, mask=3'b111 → forced RDY after 8 poll clocks; timeout_pulse 1 clock; timeout_source=3'b010; timeout_clear → 0.
- ready_mask=3'b000 with ready_in=0 → no stall beyond programmed waits.
- INTA_N=0 with IOR_N=0 → RDY remains 1 throughout.
- Command released in WAIT, then reset_n pulsed mid-POLL → IDLE with no timeout; after reset, RDY=0 until the first negedge, then 1.
